demux1_2_buf: RTL and testbench

DEMUX1_2_BUF -- requirements
Module: demux1_2_buf

---
 rtl/demux_pkg.sv | 10 +
 rtl/demux1_2_buf_fifo2.sv | 67 ++++++
 rtl/demux1_2_buf.sv | 100 ++++++++++
 tb/tb_demux1_2_buf.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 buffered demultiplexer: channel encodings,
// per-channel buffer depth and event counter width.
package demux_pkg;

  localparam logic CH_1       = 1'b0;
  localparam logic CH_2       = 1'b1;
  localparam int   FIFO_DEPTH = 2;
  localparam int   CNT_W      = 8;

endpackage

// File: rtl/demux1_2_buf_fifo2.sv
// fifo2: small synchronous FIFO (default 2 entries) with registered head data.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module fifo2
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/demux1_2_buf.sv
// demux1_2_buf: routes an input stream to one of two buffered output channels.
// Define DEMUX_AUTO_SEL_EN to ignore sel and alternate channels on each acceptance.
module demux1_2_buf #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = demux_pkg::FIFO_DEPTH
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       sel,
  output logic [DATA_W-1:0]          out_1_data,
  output logic                       out_1_valid,
  input  logic                       out_1_ready,
  output logic [DATA_W-1:0]          out_2_data,
  output logic                       out_2_valid,
  input  logic                       out_2_ready,
  output logic [demux_pkg::CNT_W-1:0] cnt_1,
  output logic [demux_pkg::CNT_W-1:0] cnt_2
);
  import demux_pkg::*;

  logic             active_ch;
  logic             full_1, full_2, empty_1, empty_2;
  logic             accept, push_1, push_2, pop_1, pop_2;
  logic [CNT_W-1:0] cnt_1_q, cnt_1_d, cnt_2_q, cnt_2_d;

`ifdef DEMUX_AUTO_SEL_EN
  logic toggle_q, toggle_d;
  logic unused_sel;

  assign unused_sel = sel;
  assign active_ch  = toggle_q;

  always_comb begin
    toggle_d = toggle_q;
    if (accept) toggle_d = ~toggle_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) toggle_q <= CH_1;
    else         toggle_q <= toggle_d;
  end
`else
  assign active_ch = sel;
`endif

  // Ready looks only at the active channel's fullness, never at the sinks.
  assign in_ready = !sys_rst && ((active_ch == CH_1) ? !full_1 : !full_2);
  assign accept   = in_valid && in_ready;
  assign push_1   = accept && (active_ch == CH_1);
  assign push_2   = accept && (active_ch == CH_2);

  assign out_1_valid = !empty_1;
  assign out_2_valid = !empty_2;
  assign pop_1       = out_1_valid && out_1_ready;
  assign pop_2       = out_2_valid && out_2_ready;

  always_comb begin
    cnt_1_d = cnt_1_q + CNT_W'(push_1);
    cnt_2_d = cnt_2_q + CNT_W'(push_2);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_1_q <= '0;
      cnt_2_q <= '0;
    end else begin
      cnt_1_q <= cnt_1_d;
      cnt_2_q <= cnt_2_d;
    end
  end

  assign cnt_1 = cnt_1_q;
  assign cnt_2 = cnt_2_q;

  fifo2 #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push_1),
    .pop   (pop_1),
    .wdata (in_data),
    .full  (full_1),
    .empty (empty_1),
    .rdata (out_1_data)
  );

  fifo2 #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_2 (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push_2),
    .pop   (pop_2),
    .wdata (in_data),
    .full  (full_2),
    .empty (empty_2),
    .rdata (out_2_data)
  );

endmodule

// File: tb/tb_demux1_2_buf.sv
// Directed self-checking bench for demux1_2_buf; the auto-select scenario
// runs only when DEMUX_AUTO_SEL_EN is defined, the sel-driven ones otherwise.
module tb_demux1_2_buf;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       sel;
  logic [7:0] out_1_data, out_2_data;
  logic       out_1_valid, out_2_valid;
  logic       out_1_ready, out_2_ready;
  logic [7:0] cnt_1, cnt_2;

  int n_pass = 0;
  int n_total = 0;

  demux1_2_buf #(.DATA_W(8)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel         (sel),
    .out_1_data  (out_1_data),
    .out_1_valid (out_1_valid),
    .out_1_ready (out_1_ready),
    .out_2_data  (out_2_data),
    .out_2_valid (out_2_valid),
    .out_2_ready (out_2_ready),
    .cnt_1       (cnt_1),
    .cnt_2       (cnt_2)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_data = 0; sel = 0; out_1_ready = 0; out_2_ready = 0;
    sys_rst = 1;
    #12;
    sys_rst = 0;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 0; in_data = 8'hFF; sel = 0; out_1_ready = 1; out_2_ready = 1;
    sys_rst = 1;
    #3;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_total++;
    if ({out_1_valid, out_2_valid} !== 2'b00) $display("FAIL reset_valids got=%b exp=00", {out_1_valid, out_2_valid}); else n_pass++;
    n_total++;
    if ({cnt_1, cnt_2} !== 16'h0000) $display("FAIL reset_counts got=%h exp=0000", {cnt_1, cnt_2}); else n_pass++;
    n_total++;
    if ({out_1_data, out_2_data} !== 16'h0000) $display("FAIL reset_data got=%h exp=0000", {out_1_data, out_2_data}); else n_pass++;
    tick();
    sys_rst = 0;
    #2;
    tick();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", in_ready); else n_pass++;
  endtask

  task automatic test_ignore();
    do_reset();
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      sel = i[0]; in_data = 8'h50 + 8'(i);
      tick();
    end
    n_total++;
    if ({out_1_valid, out_2_valid, cnt_1, cnt_2} !== 18'h0)
      $display("FAIL ignore_invalid got v=%b%b c1=%0d c2=%0d exp all 0", out_1_valid, out_2_valid, cnt_1, cnt_2);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      sel = i[1]; in_data = 8'h20 + 8'(i);
      tick();
    end
    in_valid = 0;
    n_total++;
    if ({out_1_valid, out_2_valid, cnt_1, cnt_2} !== {2'b11, 8'd2, 8'd2})
      $display("FAIL midstream_fill got v=%b%b c1=%0d c2=%0d exp v=11 c1=2 c2=2", out_1_valid, out_2_valid, cnt_1, cnt_2);
    else n_pass++;
    #2;
    sys_rst = 1;
    #1;
    n_total++;
    if ({out_1_valid, out_2_valid, in_ready, cnt_1, cnt_2} !== 19'h0)
      $display("FAIL midstream_async got v=%b%b rdy=%b c1=%0d c2=%0d exp all 0", out_1_valid, out_2_valid, in_ready, cnt_1, cnt_2);
    else n_pass++;
    out_1_ready = 1; out_2_ready = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({out_1_valid, out_2_valid} !== 2'b00) $display("FAIL midstream_hold got=%b%b exp=00", out_1_valid, out_2_valid); else n_pass++;
    end
    in_valid = 0;
    sys_rst = 0;
    tick();
    tick();
    n_total++;
    if ({out_1_valid, out_2_valid, out_1_data, out_2_data} !== 18'h0)
      $display("FAIL midstream_stale got v=%b%b d1=%h d2=%h exp all 0", out_1_valid, out_2_valid, out_1_data, out_2_data);
    else n_pass++;
  endtask

`ifndef DEMUX_AUTO_SEL_EN
  task automatic test_routing();
    do_reset();
    out_1_ready = 1; out_2_ready = 1;
    in_valid = 1; sel = 0; in_data = 8'hA5;
    tick();
    n_total++;
    if ({out_1_valid, out_1_data} !== {1'b1, 8'hA5}) $display("FAIL route_out1 got v=%b d=%h exp v=1 d=a5", out_1_valid, out_1_data); else n_pass++;
    sel = 1; in_data = 8'h3C;
    tick();
    in_valid = 0;
    n_total++;
    if ({out_2_valid, out_2_data} !== {1'b1, 8'h3C}) $display("FAIL route_out2 got v=%b d=%h exp v=1 d=3c", out_2_valid, out_2_data); else n_pass++;
    n_total++;
    if (out_1_valid !== 1'b0) $display("FAIL route_out1_drained got=%b exp=0", out_1_valid); else n_pass++;
    n_total++;
    if ({cnt_1, cnt_2} !== {8'd1, 8'd1}) $display("FAIL route_counts got c1=%0d c2=%0d exp 1 1", cnt_1, cnt_2); else n_pass++;
  endtask

  task automatic test_fill_stall();
    do_reset();
    out_1_ready = 0; sel = 0; in_valid = 1;
    in_data = 8'h01;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL fill_rdy1 got=%b exp=1", in_ready); else n_pass++;
    tick();
    in_data = 8'h02;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL fill_rdy2 got=%b exp=1", in_ready); else n_pass++;
    tick();
    in_data = 8'h03;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL fill_rdy3 got=%b exp=0", in_ready); else n_pass++;
    tick();
    n_total++;
    if ({cnt_1, out_1_data, out_1_valid} !== {8'd2, 8'h01, 1'b1})
      $display("FAIL fill_stalled got c1=%0d d=%h v=%b exp 2 01 1", cnt_1, out_1_data, out_1_valid);
    else n_pass++;
    out_1_ready = 1;
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL full_pop_ready got=%b exp=0", in_ready); else n_pass++;
    tick();
    n_total++;
    if ({out_1_data, in_ready} !== {8'h02, 1'b1}) $display("FAIL drain_word2 got d=%h rdy=%b exp 02 1", out_1_data, in_ready); else n_pass++;
    tick();
    in_valid = 0;
    n_total++;
    if ({out_1_data, out_1_valid, cnt_1} !== {8'h03, 1'b1, 8'd3})
      $display("FAIL drain_word3 got d=%h v=%b c1=%0d exp 03 1 3", out_1_data, out_1_valid, cnt_1);
    else n_pass++;
    tick();
    n_total++;
    if (out_1_valid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", out_1_valid); else n_pass++;
  endtask

  task automatic test_independence();
    do_reset();
    out_1_ready = 0; out_2_ready = 0; sel = 0; in_valid = 1;
    in_data = 8'hE1; tick();
    in_data = 8'hE2; tick();
    sel = 1; in_data = 8'h11;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL indep_ready got=%b exp=1", in_ready); else n_pass++;
    tick();
    in_valid = 0;
    n_total++;
    if ({out_2_valid, out_2_data} !== {1'b1, 8'h11}) $display("FAIL indep_out2 got v=%b d=%h exp 1 11", out_2_valid, out_2_data); else n_pass++;
    tick();
    n_total++;
    if ({out_1_valid, out_1_data, out_2_data} !== {1'b1, 8'hE1, 8'h11})
      $display("FAIL indep_hold got v1=%b d1=%h d2=%h exp 1 e1 11", out_1_valid, out_1_data, out_2_data);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    out_2_ready = 1; sel = 1; in_valid = 1;
    for (int i = 0; i < 255; i++) begin
      in_data = 8'(i);
      tick();
    end
    n_total++;
    if (cnt_2 !== 8'd255) $display("FAIL wrap_255 got=%0d exp=255", cnt_2); else n_pass++;
    in_data = 8'hFF;
    tick();
    in_valid = 0;
    n_total++;
    if ({cnt_2, cnt_1} !== 16'h0000) $display("FAIL wrap_zero got c2=%0d c1=%0d exp 0 0", cnt_2, cnt_1); else n_pass++;
  endtask
`else
  task automatic test_auto_sel();
    do_reset();
    out_1_ready = 0; out_2_ready = 0; sel = 1; in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 0;
    n_total++;
    if ({out_1_data, out_2_data, cnt_1, cnt_2} !== {8'd1, 8'd2, 8'd2, 8'd2})
      $display("FAIL auto_heads got d1=%0d d2=%0d c1=%0d c2=%0d exp 1 2 2 2", out_1_data, out_2_data, cnt_1, cnt_2);
    else n_pass++;
    out_1_ready = 1; out_2_ready = 1;
    tick();
    n_total++;
    if ({out_1_data, out_2_data} !== {8'd3, 8'd4}) $display("FAIL auto_tails got d1=%0d d2=%0d exp 3 4", out_1_data, out_2_data); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_ignore();
    test_reset_midstream();
`ifndef DEMUX_AUTO_SEL_EN
    test_routing();
    test_fill_stall();
    test_independence();
    test_wrap();
`else
    test_auto_sel();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
